// File: rtl/simple_st0_mac_seq_if.sv
// Control, memory-read and result-stream bundle of the stage-0 MAC sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface simple_st0_mac_seq_if #(
    parameter int DATA_W  = 32,
    parameter int LANES   = 6,
    parameter int DATA_AW = 6,
    parameter int TAP_AW  = 5,
    parameter int BIAS_AW = 4
) ();
    localparam int LANE_W = $clog2(LANES);

    logic                    start;
    logic [TAP_AW-1:0]       len_m1;
    logic [DATA_AW-1:0]      data_base;
    logic                    busy;
    logic                    done;

    logic                    data_rd_en;
    logic [DATA_AW-1:0]      data_rd_addr;
    logic [DATA_W-1:0]       data_rd_data;
    logic                    tap_rd_en;
    logic [TAP_AW-1:0]       tap_rd_addr;
    logic [LANES*DATA_W-1:0] tap_rd_data;
    logic                    bias_rd_en;
    logic [BIAS_AW-1:0]      bias_rd_addr;
    logic [DATA_W-1:0]       bias_rd_data;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [LANE_W-1:0]       out_lane;

    modport slave (
        input  start, len_m1, data_base, data_rd_data, tap_rd_data, bias_rd_data, out_ready,
        output busy, done, data_rd_en, data_rd_addr, tap_rd_en, tap_rd_addr,
               bias_rd_en, bias_rd_addr, out_valid, out_data, out_lane
    );

    modport master (
        output start, len_m1, data_base, data_rd_data, tap_rd_data, bias_rd_data, out_ready,
        input  busy, done, data_rd_en, data_rd_addr, tap_rd_en, tap_rd_addr,
               bias_rd_en, bias_rd_addr, out_valid, out_data, out_lane
    );
endinterface

// File: rtl/simple_st0_mac_seq.sv
// Stage-0 MAC sequencer: streams data/tap reads into six parallel accumulators,
// then adds per-lane bias, saturates to 32 bits and emits one lane per handshake.
module simple_st0_mac_seq #(
    parameter int DATA_W  = 32,
    parameter int LANES   = 6,
    parameter int DATA_AW = 6,
    parameter int TAP_AW  = 5,
    parameter int BIAS_AW = 4,
    parameter int ACC_W   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    simple_st0_mac_seq_if.slave  bus
);
    localparam int LANE_W = $clog2(LANES);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, BIAS, SUM, OUT} state_t;

    state_t               state_reg;
    logic [TAP_AW-1:0]    len_reg;
    logic [DATA_AW-1:0]   base_reg;
    logic [TAP_AW-1:0]    i_reg;
    logic [LANE_W-1:0]    j_reg;
    logic                 rd_valid_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 data_en_reg;
    logic [DATA_AW-1:0]   data_addr_reg;
    logic                 tap_en_reg;
    logic [TAP_AW-1:0]    tap_addr_reg;
    logic                 bias_en_reg;
    logic [BIAS_AW-1:0]   bias_addr_reg;
    logic                 out_valid_reg;
    logic [DATA_W-1:0]    out_data_reg;
    logic [LANE_W-1:0]    out_lane_reg;

    logic [LANES-1:0][ACC_W-1:0] acc_bus;
    logic signed [ACC_W-1:0]     acc_sel;
    logic signed [ACC_W-1:0]     sum;
    logic [DATA_W-1:0]           sat_next;
    logic                        clear_acc;

    assign clear_acc = (state_reg == IDLE) && bus.start;

    // One accumulator per lane; each sees the same data word times its own tap.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [ACC_W-1:0] prod;
            logic signed [ACC_W-1:0] acc_reg;

            assign prod = ACC_W'($signed(bus.data_rd_data)) *
                          ACC_W'($signed(bus.tap_rd_data[gi*DATA_W +: DATA_W]));
            assign acc_bus[gi] = acc_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    acc_reg <= '0;
                else if (clear_acc)
                    acc_reg <= '0;
                else if (rd_valid_reg)
                    acc_reg <= acc_reg + prod;
            end
        end
    endgenerate

    assign acc_sel = acc_bus[j_reg];
    assign sum     = acc_sel + ACC_W'($signed(bus.bias_rd_data));

    always_comb begin
        sat_next = sum[DATA_W-1:0];
        if (sum > SAT_MAX)
            sat_next = SAT_MAX[DATA_W-1:0];
        else if (sum < SAT_MIN)
            sat_next = SAT_MIN[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            base_reg      <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            rd_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            data_en_reg   <= 1'b0;
            data_addr_reg <= '0;
            tap_en_reg    <= 1'b0;
            tap_addr_reg  <= '0;
            bias_en_reg   <= 1'b0;
            bias_addr_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_lane_reg  <= '0;
        end else begin
            done_reg     <= 1'b0;
            rd_valid_reg <= data_en_reg;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        len_reg       <= bus.len_m1;
                        base_reg      <= bus.data_base;
                        i_reg         <= '0;
                        busy_reg      <= 1'b1;
                        data_en_reg   <= 1'b1;
                        data_addr_reg <= bus.data_base;
                        tap_en_reg    <= 1'b1;
                        tap_addr_reg  <= '0;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (i_reg == len_reg) begin
                        data_en_reg <= 1'b0;
                        tap_en_reg  <= 1'b0;
                        state_reg   <= DRAIN;
                    end else begin
                        // Data address wraps naturally at the 6-bit boundary.
                        i_reg         <= i_reg + 1'b1;
                        data_addr_reg <= base_reg + DATA_AW'(i_reg) + 1'b1;
                        tap_addr_reg  <= i_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    j_reg         <= '0;
                    bias_en_reg   <= 1'b1;
                    bias_addr_reg <= '0;
                    state_reg     <= BIAS;
                end
                BIAS: begin
                    bias_en_reg <= 1'b0;
                    state_reg   <= SUM;
                end
                SUM: begin
                    out_data_reg  <= sat_next;
                    out_lane_reg  <= j_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (j_reg == LANE_W'(LANES-1)) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            j_reg         <= j_reg + 1'b1;
                            bias_en_reg   <= 1'b1;
                            bias_addr_reg <= BIAS_AW'(j_reg + 1'b1);
                            state_reg     <= BIAS;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.data_rd_en   = data_en_reg;
    assign bus.data_rd_addr = data_addr_reg;
    assign bus.tap_rd_en    = tap_en_reg;
    assign bus.tap_rd_addr  = tap_addr_reg;
    assign bus.bias_rd_en   = bias_en_reg;
    assign bus.bias_rd_addr = bias_addr_reg;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_data     = out_data_reg;
    assign bus.out_lane     = out_lane_reg;
endmodule
